// File: rtl/memctrl_pkg.sv
// Shared types and constants for the memory controller: FSM encoding,
// port selector, transfer descriptor, access lengths and IO address match.
package memctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  typedef enum logic {
    PORT_IF,
    PORT_MEM
  } port_t;

  localparam logic [2:0] LEN_B = 3'd1;
  localparam logic [2:0] LEN_H = 3'd2;
  localparam logic [2:0] LEN_W = 3'd4;

  // Bits [17:16] of an address select the IO window when equal to this.
  localparam logic [1:0] IO_SEL = 2'b11;

  typedef struct packed {
    port_t       port;
    logic        wr;
    logic [2:0]  len;
    logic [31:0] addr;
    logic [31:0] wdata;
  } xfer_t;

  function automatic logic is_io(input logic [31:0] a);
    return a[17:16] == IO_SEL;
  endfunction

endpackage

// File: rtl/memctrl_arb.sv
// Request arbiter: picks the data port over the fetch port and normalises
// the access length to 1, 2 or 4 bytes.
module memctrl_arb
  import memctrl_pkg::*;
(
  input  logic        if_en_i,
  input  logic [31:0] if_addr_i,
  input  logic        mem_en_i,
  input  logic        mem_wr_i,
  input  logic [2:0]  mem_len_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  output logic        req_valid,
  output xfer_t       req
);

  always_comb begin
    // NOTE: every output gets a default before any branch, so no path leaves
    // a variable unassigned and no latch is inferred.
    req_valid = if_en_i | mem_en_i;
    req       = '{port: PORT_IF, wr: 1'b0, len: LEN_W, addr: if_addr_i, wdata: '0};
    if (mem_en_i) begin
      req.port  = PORT_MEM;
      req.wr    = mem_wr_i;
      req.addr  = mem_addr_i;
      req.wdata = mem_data_i;
      case (mem_len_i)
        LEN_B:   req.len = LEN_B;
        LEN_H:   req.len = LEN_H;
        default: req.len = LEN_W;
      endcase
    end
  end

endmodule

// File: rtl/memctrl.sv
// Byte-serial RAM bus controller for instruction fetches and data loads/stores.
// Define MEMCTRL_IOFULL_EN to add io_buffer_full back-pressure on IO-window stores.
module memctrl
  import memctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic        if_en_i,
  input  logic [31:0] if_addr_i,
  output logic        if_rdy_o,
  output logic [31:0] if_inst_o,
  input  logic        mem_en_i,
  input  logic        mem_wr_i,
  input  logic [2:0]  mem_len_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  output logic        mem_rdy_o,
  output logic [31:0] mem_data_o,
`ifdef MEMCTRL_IOFULL_EN
  input  logic        io_buffer_full,
`endif
  input  logic [7:0]  ram_din,
  output logic [7:0]  ram_dout,
  output logic [31:0] ram_a,
  output logic        ram_wr
);

  state_t      state, state_n;
  xfer_t       req, cur;
  logic        req_valid;
  logic [2:0]  cnt;
  logic [31:0] rdata, rdata_cap, issue_addr, wshift;
  logic [1:0]  cap_idx;
  logic        accept, abort, capture, issue, rd_done, wr_done;
  logic        io_gap, io_stall, acc_stall;

  memctrl_arb u_arb (
    .if_en_i    (if_en_i),
    .if_addr_i  (if_addr_i),
    .mem_en_i   (mem_en_i),
    .mem_wr_i   (mem_wr_i),
    .mem_len_i  (mem_len_i),
    .mem_addr_i (mem_addr_i),
    .mem_data_i (mem_data_i),
    .req_valid  (req_valid),
    .req        (req)
  );

  assign issue_addr = cur.addr + {29'd0, cnt};
  assign wshift     = cur.wdata >> {cnt[1:0], 3'b000};
  // In READ, cnt runs one ahead of the byte arriving on ram_din.
  assign cap_idx    = cnt[1:0] - 2'd1;

`ifdef MEMCTRL_IOFULL_EN
  assign io_gap    = ram_wr && is_io(ram_a);
  assign io_stall  = io_buffer_full && is_io(issue_addr);
  assign acc_stall = io_buffer_full && is_io(req.addr);
`else
  assign io_gap    = 1'b0;
  assign io_stall  = 1'b0;
  assign acc_stall = 1'b0;
`endif

  always_comb begin
    rdata_cap = rdata;
    rdata_cap[{cap_idx, 3'b000} +: 8] = ram_din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n)   state <= S_IDLE;
    else if (rdy) state <= state_n;
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    abort   = 1'b0;
    capture = 1'b0;
    issue   = 1'b0;
    rd_done = 1'b0;
    wr_done = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        state_n = S_IDLE;
        if (req_valid) begin
          accept  = 1'b1;
          state_n = req.wr ? S_WRITE : S_READ;
        end
      end
      S_READ: begin
        if (cur.port == PORT_IF && (!if_en_i || if_addr_i != cur.addr)) begin
          abort   = 1'b1;
          state_n = S_IDLE;
        end else begin
          capture = (cnt != 3'd0);
          if (cnt == cur.len) begin
            rd_done = 1'b1;
            state_n = S_DONE;
          end
        end
      end
      S_WRITE: begin
        if (!io_gap) begin
          if (cnt == cur.len) begin
            wr_done = 1'b1;
            state_n = S_DONE;
          end else if (!io_stall) begin
            issue = 1'b1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur        <= '0;
      cnt        <= '0;
      rdata      <= '0;
      ram_a      <= '0;
      ram_dout   <= '0;
      ram_wr     <= 1'b0;
      if_rdy_o   <= 1'b0;
      mem_rdy_o  <= 1'b0;
      if_inst_o  <= '0;
      mem_data_o <= '0;
    end else if (rdy) begin
      ram_wr    <= 1'b0;
      if_rdy_o  <= 1'b0;
      mem_rdy_o <= 1'b0;

      if (accept) begin
        cur   <= req;
        rdata <= '0;
        ram_a <= req.addr;
        cnt   <= '0;
        if (req.wr && !acc_stall) begin
          ram_wr   <= 1'b1;
          ram_dout <= req.wdata[7:0];
          cnt      <= 3'd1;
        end
      end

      if (state == S_READ && !abort) begin
        cnt <= cnt + 3'd1;
        if (cnt + 3'd1 < cur.len) ram_a <= ram_a + 32'd1;
        if (capture) rdata <= rdata_cap;
        if (rd_done) begin
          if (cur.port == PORT_IF) begin
            if_rdy_o  <= 1'b1;
            if_inst_o <= rdata_cap;
          end else begin
            mem_rdy_o  <= 1'b1;
            mem_data_o <= rdata_cap;
          end
        end
      end

      if (issue) begin
        ram_wr   <= 1'b1;
        ram_a    <= issue_addr;
        ram_dout <= wshift[7:0];
        cnt      <= cnt + 3'd1;
      end

      if (wr_done) mem_rdy_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_memctrl.sv
// Directed testbench for memctrl with a one-cycle-latency byte RAM model.
module tb_memctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b1;
  logic        if_en_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic        if_rdy_o;
  logic [31:0] if_inst_o;
  logic        mem_en_i = 1'b0;
  logic        mem_wr_i = 1'b0;
  logic [2:0]  mem_len_i = 3'd4;
  logic [31:0] mem_addr_i = '0;
  logic [31:0] mem_data_i = '0;
  logic        mem_rdy_o;
  logic [31:0] mem_data_o;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;
`ifdef MEMCTRL_IOFULL_EN
  logic        io_buffer_full = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  ram_mem [0:65535];
  logic [31:0] wr_a [$];
  logic [7:0]  wr_d [$];

  memctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rdy            (rdy),
    .if_en_i        (if_en_i),
    .if_addr_i      (if_addr_i),
    .if_rdy_o       (if_rdy_o),
    .if_inst_o      (if_inst_o),
    .mem_en_i       (mem_en_i),
    .mem_wr_i       (mem_wr_i),
    .mem_len_i      (mem_len_i),
    .mem_addr_i     (mem_addr_i),
    .mem_data_i     (mem_data_i),
    .mem_rdy_o      (mem_rdy_o),
    .mem_data_o     (mem_data_o),
`ifdef MEMCTRL_IOFULL_EN
    .io_buffer_full (io_buffer_full),
`endif
    .ram_din        (ram_din),
    .ram_dout       (ram_dout),
    .ram_a          (ram_a),
    .ram_wr         (ram_wr)
  );

  always #5 clk = ~clk;

  // RAM model: 64 KiB mirror on ram_a[15:0], frozen together with the DUT by rdy.
  always @(posedge clk) begin
    if (!rst_n) begin
      ram_mem[16'h1000] <= 8'h13;
      ram_mem[16'h1001] <= 8'h05;
      ram_mem[16'h1002] <= 8'h00;
      ram_mem[16'h1003] <= 8'h00;
      ram_mem[16'h2000] <= 8'h78;
      ram_mem[16'h2001] <= 8'h56;
      ram_mem[16'h2002] <= 8'h34;
      ram_mem[16'h2003] <= 8'h12;
      ram_mem[16'hFFFF] <= 8'hEE;
      ram_mem[16'h0000] <= 8'h11;
      ram_din           <= 8'h00;
    end else if (rdy) begin
      if (ram_wr) begin
        ram_mem[ram_a[15:0]] <= ram_dout;
        wr_a.push_back(ram_a);
        wr_d.push_back(ram_dout);
      end
      ram_din <= ram_mem[ram_a[15:0]];
    end
  end

  task automatic wait_rdy(input bit on_mem, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(on_mem ? mem_rdy_o : if_rdy_o) && n < 40);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++; if ({if_rdy_o, mem_rdy_o, ram_wr} !== 3'b000) begin n_bad++; $display("FAIL reset_strobes: got %b want 000", {if_rdy_o, mem_rdy_o, ram_wr}); end
    n_cmp++; if (ram_a !== 32'h0) begin n_bad++; $display("FAIL reset_ram_a: got %h want 0", ram_a); end
    n_cmp++; if (ram_dout !== 8'h0) begin n_bad++; $display("FAIL reset_ram_dout: got %h want 0", ram_dout); end
    n_cmp++; if (if_inst_o !== 32'h0) begin n_bad++; $display("FAIL reset_if_inst: got %h want 0", if_inst_o); end
    n_cmp++; if (mem_data_o !== 32'h0) begin n_bad++; $display("FAIL reset_mem_data: got %h want 0", mem_data_o); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fetch();
    int n;
    if_addr_i = 32'h0000_1000;
    if_en_i   = 1'b1;
    wait_rdy(1'b0, n);
    if_en_i = 1'b0;
    n_cmp++; if (n !== 6) begin n_bad++; $display("FAIL fetch_latency: got %0d want 6", n); end
    n_cmp++; if (if_inst_o !== 32'h0000_0513) begin n_bad++; $display("FAIL fetch_data: got %h want 00000513", if_inst_o); end
    @(negedge clk);
    n_cmp++; if (if_rdy_o !== 1'b0) begin n_bad++; $display("FAIL fetch_pulse_width: got %b want 0", if_rdy_o); end
  endtask

  task automatic test_priority();
    int n;
    if_addr_i  = 32'h0000_1000;
    if_en_i    = 1'b1;
    mem_addr_i = 32'h0000_2000;
    mem_len_i  = 3'd4;
    mem_wr_i   = 1'b0;
    mem_en_i   = 1'b1;
    wait_rdy(1'b1, n);
    mem_en_i = 1'b0;
    n_cmp++; if (n !== 6) begin n_bad++; $display("FAIL prio_load_latency: got %0d want 6", n); end
    n_cmp++; if (mem_data_o !== 32'h1234_5678) begin n_bad++; $display("FAIL prio_load_data: got %h want 12345678", mem_data_o); end
    n_cmp++; if (if_rdy_o !== 1'b0) begin n_bad++; $display("FAIL prio_if_quiet: got %b want 0", if_rdy_o); end
    wait_rdy(1'b0, n);
    if_en_i = 1'b0;
    n_cmp++; if (n !== 6) begin n_bad++; $display("FAIL prio_fetch_latency: got %0d want 6", n); end
    n_cmp++; if (if_inst_o !== 32'h0000_0513) begin n_bad++; $display("FAIL prio_fetch_data: got %h want 00000513", if_inst_o); end
    @(negedge clk);
  endtask

  task automatic test_store_load();
    int n;
    int base;
    base       = wr_a.size();
    mem_addr_i = 32'h0000_0010;
    mem_len_i  = 3'd2;
    mem_wr_i   = 1'b1;
    mem_data_i = 32'hAABB_CCDD;
    mem_en_i   = 1'b1;
    wait_rdy(1'b1, n);
    n_cmp++; if (n !== 3) begin n_bad++; $display("FAIL store_latency: got %0d want 3", n); end
    n_cmp++; if (wr_a.size() - base !== 2) begin n_bad++; $display("FAIL store_count: got %0d want 2", wr_a.size() - base); end
    n_cmp++;
    if ({wr_a[base], wr_d[base], wr_a[base+1], wr_d[base+1]} !== {32'h10, 8'hDD, 32'h11, 8'hCC}) begin
      n_bad++; $display("FAIL store_bytes: got %h=%h %h=%h want 10=dd 11=cc", wr_a[base], wr_d[base], wr_a[base+1], wr_d[base+1]);
    end
    mem_addr_i = 32'h0000_0011;
    mem_len_i  = 3'd1;
    mem_wr_i   = 1'b0;
    wait_rdy(1'b1, n);
    mem_en_i = 1'b0;
    n_cmp++; if (n !== 3) begin n_bad++; $display("FAIL load_b_latency: got %0d want 3", n); end
    n_cmp++; if (mem_data_o !== 32'h0000_00CC) begin n_bad++; $display("FAIL load_b_data: got %h want 000000cc", mem_data_o); end
    @(negedge clk);
  endtask

  task automatic test_len_wrap();
    int n;
    mem_addr_i = 32'h0000_2000;
    mem_len_i  = 3'd3;
    mem_wr_i   = 1'b0;
    mem_en_i   = 1'b1;
    wait_rdy(1'b1, n);
    n_cmp++; if (n !== 6) begin n_bad++; $display("FAIL len3_latency: got %0d want 6", n); end
    n_cmp++; if (mem_data_o !== 32'h1234_5678) begin n_bad++; $display("FAIL len3_data: got %h want 12345678", mem_data_o); end
    mem_addr_i = 32'hFFFF_FFFF;
    mem_len_i  = 3'd2;
    wait_rdy(1'b1, n);
    mem_en_i = 1'b0;
    n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL wrap_latency: got %0d want 4", n); end
    n_cmp++; if (mem_data_o !== 32'h0000_11EE) begin n_bad++; $display("FAIL wrap_data: got %h want 000011ee", mem_data_o); end
    @(negedge clk);
  endtask

  task automatic test_abort();
    int n;
    int base;
    bit seen;
    base      = wr_a.size();
    seen      = 1'b0;
    if_addr_i = 32'h0000_1000;
    if_en_i   = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (if_rdy_o) seen = 1'b1;
    end
    if_addr_i = 32'h0000_2000;
    wait_rdy(1'b0, n);
    if_en_i = 1'b0;
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL abort_early_rdy: got %b want 0", seen); end
    n_cmp++; if (n !== 7) begin n_bad++; $display("FAIL abort_refetch_latency: got %0d want 7", n); end
    n_cmp++; if (if_inst_o !== 32'h1234_5678) begin n_bad++; $display("FAIL abort_refetch_data: got %h want 12345678", if_inst_o); end
    n_cmp++; if (wr_a.size() !== base) begin n_bad++; $display("FAIL abort_no_write: got %0d want %0d", wr_a.size(), base); end
    @(negedge clk);
  endtask

  task automatic test_rdy_stall();
    int n;
    mem_addr_i = 32'h0000_2000;
    mem_len_i  = 3'd4;
    mem_wr_i   = 1'b0;
    mem_en_i   = 1'b1;
    repeat (2) @(negedge clk);
    rdy = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (ram_a !== 32'h0000_2001) begin n_bad++; $display("FAIL stall_ram_a: got %h want 00002001", ram_a); end
    @(negedge clk);
    rdy = 1'b1;
    wait_rdy(1'b1, n);
    mem_en_i = 1'b0;
    n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL stall_latency: got %0d want 4", n); end
    n_cmp++; if (mem_data_o !== 32'h1234_5678) begin n_bad++; $display("FAIL stall_data: got %h want 12345678", mem_data_o); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int base;
    base       = wr_a.size();
    mem_addr_i = 32'h0000_0040;
    mem_len_i  = 3'd4;
    mem_wr_i   = 1'b1;
    mem_data_i = 32'h4433_2211;
    mem_en_i   = 1'b1;
    repeat (2) @(negedge clk);
    rst_n    = 1'b0;
    mem_en_i = 1'b0;
    #1;
    n_cmp++; if ({ram_wr, mem_rdy_o} !== 2'b00) begin n_bad++; $display("FAIL midreset_strobes: got %b want 00", {ram_wr, mem_rdy_o}); end
    n_cmp++; if (ram_a !== 32'h0) begin n_bad++; $display("FAIL midreset_ram_a: got %h want 0", ram_a); end
    @(negedge clk);
    rst_n = 1'b1;
    n_cmp++;
    if ({wr_a.size() - base, wr_d[base]} !== {32'd1, 8'h11}) begin
      n_bad++; $display("FAIL midreset_partial: got count %0d byte %h want count 1 byte 11", wr_a.size() - base, wr_d[base]);
    end
    @(negedge clk);
  endtask

`ifdef MEMCTRL_IOFULL_EN
  task automatic test_iofull();
    int n;
    int base;
    int low;
    base           = wr_a.size();
    low            = 0;
    io_buffer_full = 1'b1;
    mem_addr_i     = 32'h0003_0000;
    mem_len_i      = 3'd1;
    mem_wr_i       = 1'b1;
    mem_data_i     = 32'h0000_005A;
    mem_en_i       = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (!ram_wr) low++;
    end
    io_buffer_full = 1'b0;
    n_cmp++; if (low !== 4) begin n_bad++; $display("FAIL io_held_low: got %0d want 4", low); end
    @(negedge clk);
    n_cmp++;
    if ({ram_wr, ram_a, ram_dout} !== {1'b1, 32'h0003_0000, 8'h5A}) begin
      n_bad++; $display("FAIL io_write: got wr=%b a=%h d=%h want wr=1 a=00030000 d=5a", ram_wr, ram_a, ram_dout);
    end
    wait_rdy(1'b1, n);
    mem_en_i = 1'b0;
    n_cmp++; if (n !== 2) begin n_bad++; $display("FAIL io_done_latency: got %0d want 2", n); end
    n_cmp++; if (wr_a.size() - base !== 1) begin n_bad++; $display("FAIL io_write_count: got %0d want 1", wr_a.size() - base); end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_store_load();
    test_len_wrap();
    test_abort();
    test_rdy_stall();
    test_reset_mid();
`ifdef MEMCTRL_IOFULL_EN
    test_iofull();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
